// File: rtl/clk_div_cfg_pkg.sv
// -----------------------------------------------------------------------------
// clk_div_cfg_pkg
// Shared types and constants for the clock divider configuration master.
//   state_e     : handshake FSM states (IDLE, REQ, REL)
//   SYNC_STAGES : depth of the ack level synchronizer
//   DIV_W       : width of a divider value
// -----------------------------------------------------------------------------
package clk_div_cfg_pkg;

  localparam int SYNC_STAGES = 2;
  localparam int DIV_W       = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    REL  = 2'd2
  } state_e;

endpackage

// File: rtl/pulp_sync_2ff.sv
// -----------------------------------------------------------------------------
// pulp_sync_2ff
// Generic multi-flop level synchronizer for a single asynchronous bit.
// Ports:
//   clk : destination clock
//   rst : synchronous active-high reset, clears every stage
//   d   : asynchronous level input
//   q   : synchronized level, STAGES cycles behind d
// -----------------------------------------------------------------------------
module pulp_sync_2ff
  import clk_div_cfg_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  // Plain shift chain; the first flop may go metastable, later ones settle it.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/clk_div_cfg_ctrl.sv
// -----------------------------------------------------------------------------
// clk_div_cfg_ctrl
// Upstream master for one clock_divider. Turns single-cycle software writes
// into a 4-phase level handshake (valid/ack) with data held stable, keeps one
// pending write (latest wins), and flags phases that take too long.
// Ports:
//   clk_i           : soc_ctrl clock
//   rst_i           : synchronous active-high reset
//   cfg_div_i       : new divider value, sampled with cfg_we_i
//   cfg_we_i        : single-cycle write strobe
//   err_clr_i       : clears the sticky timeout flag
//   clk_div_ack_i   : asynchronous ack level from the divider
//   clk_div_data_o  : divider value presented to the divider
//   clk_div_valid_o : request level
//   busy_o          : handshake in progress
//   pending_o       : a queued write waits for launch
//   err_o           : sticky timeout flag
//   cur_div_o       : last value acknowledged by the divider
// -----------------------------------------------------------------------------
module clk_div_cfg_ctrl
  import clk_div_cfg_pkg::*;
#(
  parameter logic [DIV_W-1:0] DIV_INIT    = '0,
  parameter int               TIMEOUT_CYC = 1024,
  localparam int              CNT_W       = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [DIV_W-1:0] cfg_div_i,
  input  logic             cfg_we_i,
  input  logic             err_clr_i,
  input  logic             clk_div_ack_i,
  output logic [DIV_W-1:0] clk_div_data_o,
  output logic             clk_div_valid_o,
  output logic             busy_o,
  output logic             pending_o,
  output logic             err_o,
  output logic [DIV_W-1:0] cur_div_o
);

  // The counter reads TIMEOUT_CYC-1 during the last allowed cycle of a phase.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_e           state_q, state_d;
  logic             valid_q, valid_d;
  logic [DIV_W-1:0] data_q, data_d;
  logic [DIV_W-1:0] cur_q, cur_d;
  logic             pend_q, pend_d;
  logic [DIV_W-1:0] pend_data_q, pend_data_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ack_s;
  logic             phase_expired;

  pulp_sync_2ff #(
    .STAGES(SYNC_STAGES)
  ) u_ack_sync (
    .clk(clk_i),
    .rst(rst_i),
    .d  (clk_div_ack_i),
    .q  (ack_s)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      valid_q     <= 1'b0;
      data_q      <= DIV_INIT;
      cur_q       <= DIV_INIT;
      pend_q      <= 1'b0;
      pend_data_q <= DIV_INIT;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      cur_q       <= cur_d;
      pend_q      <= pend_d;
      pend_data_q <= pend_data_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign phase_expired = (cnt_q == CNT_LAST);

  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    data_d      = data_q;
    cur_d       = cur_q;
    pend_d      = pend_q;
    pend_data_d = pend_data_q;
    err_d       = err_q;

    // Clear first so a timeout in the same cycle overrides it.
    if (err_clr_i) begin
      err_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        // Launch only while the divider's ack is low, so it always sees a
        // clean rising valid; otherwise an incoming write is parked.
        if (!ack_s && pend_q) begin
          data_d  = pend_data_q;
          valid_d = 1'b1;
          state_d = REQ;
          pend_d  = cfg_we_i;
          if (cfg_we_i) begin
            pend_data_d = cfg_div_i;
          end
        end else if (!ack_s && cfg_we_i) begin
          data_d  = cfg_div_i;
          valid_d = 1'b1;
          state_d = REQ;
        end else if (cfg_we_i) begin
          pend_d      = 1'b1;
          pend_data_d = cfg_div_i;
        end
      end
      REQ: begin
        if (cfg_we_i) begin
          pend_d      = 1'b1;
          pend_data_d = cfg_div_i;
        end
        if (ack_s) begin
          cur_d   = data_q;
          valid_d = 1'b0;
          state_d = REL;
        end else if (phase_expired) begin
          err_d   = 1'b1;
          valid_d = 1'b0;
          state_d = REL;
        end
      end
      REL: begin
        if (cfg_we_i) begin
          pend_d      = 1'b1;
          pend_data_d = cfg_div_i;
        end
        if (!ack_s) begin
          state_d = IDLE;
        end else if (phase_expired) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase

    // Counts cycles spent in the current REQ/REL phase.
    if (state_d != state_q || state_q == IDLE) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign clk_div_data_o  = data_q;
  assign clk_div_valid_o = valid_q;
  assign busy_o          = (state_q != IDLE);
  assign pending_o       = pend_q;
  assign err_o           = err_q;
  assign cur_div_o       = cur_q;

endmodule

// File: tb/tb_clk_div_cfg_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clk_div_cfg_ctrl
// Self-checking bench: a divider emulator echoes valid as ack after a delay,
// a behavioural model predicts every output each cycle, and directed
// scenarios pin the model with hand-computed values before a random run.
// -----------------------------------------------------------------------------
module tb_clk_div_cfg_ctrl;

  localparam int          TO   = 8;
  localparam logic [7:0]  INIT = 8'd3;
  localparam int          P_IDLE = 0;
  localparam int          P_REQ  = 1;
  localparam int          P_REL  = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] cfg_div;
  logic       cfg_we;
  logic       err_clr;
  logic       ack;
  logic [7:0] div_data;
  logic       div_valid;
  logic       busy;
  logic       pending;
  logic       err;
  logic [7:0] cur_div;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  clk_div_cfg_ctrl #(
    .DIV_INIT   (INIT),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .cfg_div_i      (cfg_div),
    .cfg_we_i       (cfg_we),
    .err_clr_i      (err_clr),
    .clk_div_ack_i  (ack),
    .clk_div_data_o (div_data),
    .clk_div_valid_o(div_valid),
    .busy_o         (busy),
    .pending_o      (pending),
    .err_o          (err),
    .cur_div_o      (cur_div)
  );

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change on the falling edge so the rising edge sees them settled.
  task automatic applyStimulus(input logic we, input logic [7:0] div, input logic clr);
    @(negedge clk);
    cfg_we  = we;
    cfg_div = div;
    err_clr = clr;
  endtask

  // Returns on the falling edge after the strobe has been sampled.
  task automatic writeDiv(input logic [7:0] div);
    applyStimulus(1'b1, div, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
  endtask

  task automatic waitIdle(input string name);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (busy === 1'b0 && pending === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput(name, {7'd0, ok}, 8'd1);
  endtask

  // Divider emulation: ack follows valid after ack_delay cycles unless stuck.
  int         ack_delay = 3;
  bit         ack_stuck = 1'b0;
  logic [7:0] vhist     = 8'd0;

  initial begin
    ack = 1'b0;
    forever begin
      @(negedge clk);
      vhist = {vhist[6:0], (div_valid === 1'b1)};
      ack   = ack_stuck ? 1'b0 : vhist[ack_delay-1];
    end
  end

  // Behavioural model, advanced on every rising edge from the sampled inputs.
  int         m_phase = P_IDLE;
  int         m_age   = 0;
  logic       m_valid, m_pend, m_err;
  logic [7:0] m_data, m_cur, m_pdata;
  logic       m_s1, m_s2;
  bit         m_on = 1'b0;

  initial begin : model_proc
    logic acks;
    int   prev;
    bit   expired;
    forever begin
      @(posedge clk);
      if (rst === 1'b1) begin
        m_phase = P_IDLE;
        m_age   = 0;
        m_valid = 1'b0;
        m_data  = INIT;
        m_cur   = INIT;
        m_pend  = 1'b0;
        m_pdata = INIT;
        m_err   = 1'b0;
        m_s1    = 1'b0;
        m_s2    = 1'b0;
        m_on    = 1'b1;
      end else if (m_on) begin
        acks = m_s2;
        m_s2 = m_s1;
        m_s1 = ack;
        prev = m_phase;
        if (err_clr) m_err = 1'b0;
        if (m_phase == P_IDLE) begin
          if (!acks && (m_pend || cfg_we)) begin
            m_data  = m_pend ? m_pdata : cfg_div;
            m_valid = 1'b1;
            m_phase = P_REQ;
            if (m_pend) begin
              m_pend = cfg_we;
              if (cfg_we) m_pdata = cfg_div;
            end
          end else if (cfg_we) begin
            m_pend  = 1'b1;
            m_pdata = cfg_div;
          end
        end else begin
          if (cfg_we) begin
            m_pend  = 1'b1;
            m_pdata = cfg_div;
          end
          expired = (m_age + 1 >= TO);
          if (m_phase == P_REQ) begin
            if (acks) begin
              m_cur   = m_data;
              m_valid = 1'b0;
              m_phase = P_REL;
            end else if (expired) begin
              m_err   = 1'b1;
              m_valid = 1'b0;
              m_phase = P_REL;
            end
          end else begin
            if (!acks) begin
              m_phase = P_IDLE;
            end else if (expired) begin
              m_err   = 1'b1;
              m_phase = P_IDLE;
            end
          end
        end
        m_age = (m_phase == prev && m_phase != P_IDLE) ? m_age + 1 : 0;
      end
    end
  end

  // Every-cycle comparison against the model, plus a record of launched values.
  logic [7:0] launches[$];
  logic       prev_valid = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (m_on) begin
        checkOutput("valid",   {7'd0, div_valid}, {7'd0, m_valid});
        checkOutput("data",    div_data, m_data);
        checkOutput("busy",    {7'd0, busy}, {7'd0, (m_phase != P_IDLE)});
        checkOutput("pending", {7'd0, pending}, {7'd0, m_pend});
        checkOutput("err",     {7'd0, err}, {7'd0, m_err});
        checkOutput("cur_div", cur_div, m_cur);
        if (div_valid === 1'b1 && prev_valid !== 1'b1) launches.push_back(div_data);
        prev_valid = div_valid;
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cnt;
    bit found;
    rst     = 1'b1;
    cfg_we  = 1'b0;
    cfg_div = 8'h00;
    err_clr = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_data",  div_data, 8'h03);
    checkOutput("reset_cur",   cur_div, 8'h03);
    checkOutput("reset_valid", {7'd0, div_valid}, 8'd0);
    checkOutput("reset_busy",  {7'd0, busy}, 8'd0);
    checkOutput("reset_err",   {7'd0, err}, 8'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single write completes one handshake.
    launches.delete();
    writeDiv(8'h05);
    checkOutput("s1_valid_rise", {7'd0, div_valid}, 8'd1);
    checkOutput("s1_data", div_data, 8'h05);
    waitIdle("s1_idle");
    checkOutput("s1_cur", cur_div, 8'h05);
    checkOutput("s1_launches", 8'(launches.size()), 8'd1);

    // Two writes while busy: only the latest is launched.
    launches.delete();
    writeDiv(8'h05);
    applyStimulus(1'b1, 8'h07, 1'b0);
    applyStimulus(1'b1, 8'h09, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("s2_pending", {7'd0, pending}, 8'd1);
    waitIdle("s2_idle");
    checkOutput("s2_launches", 8'(launches.size()), 8'd2);
    if (launches.size() == 2) checkOutput("s2_second", launches[1], 8'h09);
    checkOutput("s2_cur", cur_div, 8'h09);

    // Ack never arrives: valid held TO cycles, then error, cur unchanged.
    ack_stuck = 1'b1;
    writeDiv(8'h11);
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      if (div_valid !== 1'b1) break;
      cnt++;
      @(negedge clk);
    end
    checkOutput("s3_valid_cycles", 8'(cnt), 8'(TO));
    checkOutput("s3_err", {7'd0, err}, 8'd1);
    checkOutput("s3_cur", cur_div, 8'h09);
    waitIdle("s3_idle");
    applyStimulus(1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("s3_err_cleared", {7'd0, err}, 8'd0);
    // Clear held high through a second timeout: the set wins.
    applyStimulus(1'b1, 8'h22, 1'b1);
    for (int i = 0; i < 50; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1);
      if (div_valid !== 1'b1) break;
    end
    checkOutput("s3_set_wins", {7'd0, err}, 8'd1);
    applyStimulus(1'b0, 8'h00, 1'b0);
    ack_stuck = 1'b0;
    waitIdle("s3_idle2");
    checkOutput("s3_cur2", cur_div, 8'h09);

    // Reset in REQ with a pending write.
    writeDiv(8'h0A);
    applyStimulus(1'b1, 8'h0B, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("s4_pending_before", {7'd0, pending}, 8'd1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("s4_valid", {7'd0, div_valid}, 8'd0);
    checkOutput("s4_busy", {7'd0, busy}, 8'd0);
    checkOutput("s4_pending", {7'd0, pending}, 8'd0);
    checkOutput("s4_cur", cur_div, 8'h03);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    writeDiv(8'h02);
    waitIdle("s4_idle");
    checkOutput("s4_cur_after", cur_div, 8'h02);

    // Write lands in the exact cycle the pending value launches.
    launches.delete();
    writeDiv(8'h01);
    applyStimulus(1'b1, 8'h04, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b0);
      if (busy === 1'b0 && pending === 1'b1) begin
        cfg_we  = 1'b1;
        cfg_div = 8'h06;
        found   = 1'b1;
        break;
      end
    end
    checkOutput("s5_found_launch", {7'd0, found}, 8'd1);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("s5_data", div_data, 8'h04);
    checkOutput("s5_pending", {7'd0, pending}, 8'd1);
    waitIdle("s5_idle");
    checkOutput("s5_launches", 8'(launches.size()), 8'd3);
    if (launches.size() == 3) begin
      checkOutput("s5_first", launches[1], 8'h04);
      checkOutput("s5_second", launches[2], 8'h06);
    end
    checkOutput("s5_cur", cur_div, 8'h06);

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      applyStimulus(($urandom % 6) == 0, 8'($urandom), ($urandom % 10) == 0);
      if (($urandom % 50) == 0) ack_delay = $urandom_range(1, 4);
      if (($urandom % 80) == 0) ack_stuck = ~ack_stuck;
      rst = (($urandom % 300) == 0);
    end
    applyStimulus(1'b0, 8'h00, 1'b0);
    rst       = 1'b0;
    ack_stuck = 1'b0;
    ack_delay = 3;
    waitIdle("rand_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
